// File: rtl/fpu_exp_addsub_pipe.sv
// fpu_exp_addsub_pipe: pipelined biased-exponent combiner for the FPU.
// Computes e1+e2-BIAS (multiply) or e1-e2+BIAS (divide), flags overflow and
// underflow of the true result, optionally saturates, and carries a tag.
// A single global advance signal moves the whole pipeline or stalls it.
module fpu_exp_addsub_pipe #(
  parameter int EXP_W  = 8,
  parameter int BIAS   = 128,
  parameter int STAGES = 2,
  parameter int SAT    = 0,
  parameter int TAG_W  = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [EXP_W-1:0] exp1,
  input  logic [EXP_W-1:0] exp2,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] sum,
  output logic             ovf,
  output logic             unf,
  output logic [TAG_W-1:0] tag_out,
  input  logic             clr_flags,
  output logic             ovf_sticky,
  output logic             unf_sticky
);

  // Two extra bits: one for the carry out of the add, one for the sign.
  localparam int CW = EXP_W + 2;

  logic signed [CW-1:0] w_e1;
  logic signed [CW-1:0] w_e2;
  logic signed [CW-1:0] w_bias;
  logic signed [CW-1:0] w_max;
  logic signed [CW-1:0] w_t;
  logic                 w_ovf;
  logic                 w_unf;
  logic [EXP_W-1:0]     w_sum;
  logic                 w_adv;
  logic                 w_xfer;

  logic                 r_valid [STAGES];
  logic [EXP_W-1:0]     r_sum   [STAGES];
  logic                 r_ovf   [STAGES];
  logic                 r_unf   [STAGES];
  logic [TAG_W-1:0]     r_tag   [STAGES];
  logic                 r_ovf_sticky;
  logic                 r_unf_sticky;

  assign w_e1   = $signed({2'b00, exp1});
  assign w_e2   = $signed({2'b00, exp2});
  assign w_bias = CW'(BIAS);
  assign w_max  = $signed({2'b00, {EXP_W{1'b1}}});

  // True signed result, range checks and optional saturation of stage-1 data.
  always_comb begin
    w_t   = op_sub ? (w_e1 - w_e2 + w_bias) : (w_e1 + w_e2 - w_bias);
    w_unf = w_t[CW-1];
    w_ovf = !w_unf && (w_t > w_max);
    w_sum = w_t[EXP_W-1:0];
    if (SAT != 0) begin
      if (w_ovf) begin
        w_sum = {EXP_W{1'b1}};
      end else if (w_unf) begin
        w_sum = '0;
      end
    end
  end

  // The pipeline moves only when the last stage is empty or being consumed.
  assign w_adv    = !r_valid[STAGES-1] || out_ready;
  assign in_ready = w_adv;
  assign w_xfer   = r_valid[STAGES-1] && out_ready;

  // Shift all stages together on advance; bubbles travel like real entries.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < STAGES; i++) begin
        r_valid[i] <= 1'b0;
        r_sum[i]   <= '0;
        r_ovf[i]   <= 1'b0;
        r_unf[i]   <= 1'b0;
        r_tag[i]   <= '0;
      end
    end else if (w_adv) begin
      r_valid[0] <= in_valid;
      r_sum[0]   <= w_sum;
      r_ovf[0]   <= w_ovf;
      r_unf[0]   <= w_unf;
      r_tag[0]   <= tag_in;
      for (int i = 1; i < STAGES; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_sum[i]   <= r_sum[i-1];
        r_ovf[i]   <= r_ovf[i-1];
        r_unf[i]   <= r_unf[i-1];
        r_tag[i]   <= r_tag[i-1];
      end
    end
  end

  // Sticky flags accumulate on real transfers only; a set beats a clear.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_ovf_sticky <= 1'b0;
      r_unf_sticky <= 1'b0;
    end else begin
      if (w_xfer && r_ovf[STAGES-1]) begin
        r_ovf_sticky <= 1'b1;
      end else if (clr_flags) begin
        r_ovf_sticky <= 1'b0;
      end
      if (w_xfer && r_unf[STAGES-1]) begin
        r_unf_sticky <= 1'b1;
      end else if (clr_flags) begin
        r_unf_sticky <= 1'b0;
      end
    end
  end

  assign out_valid  = r_valid[STAGES-1];
  assign sum        = r_sum[STAGES-1];
  assign ovf        = r_ovf[STAGES-1];
  assign unf        = r_unf[STAGES-1];
  assign tag_out    = r_tag[STAGES-1];
  assign ovf_sticky = r_ovf_sticky;
  assign unf_sticky = r_unf_sticky;

endmodule
